param_table_streamer: RTL and testbench

- Read-out side of the elaborated-parameter flow. Other blocks compute constants at elaboration time (numeric literals, arithmetic expressions, $clog2 results, local parameters); this block delivers those constants to software at run time.
- Holds a compile-time table of N_PARAMS words.
- On request, streams the table, or part of it, out through a valid/ready stream interface with an index tag and a last flag.
- Sits between the platform's control bus bridge and the stream fabric. Software uses it to verify the build configuration.

---
 rtl/param_table_streamer.sv | 86 ++++++++
 tb/tb_param_table_streamer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/param_table_streamer.sv
// param_table_streamer: streams a compile-time constant table over a valid/ready
// interface with index tag and last flag, for run-time build verification.
module param_table_streamer #(
  parameter int N_PARAMS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int INDEX_WIDTH = $clog2(N_PARAMS) + 1,
  parameter logic [N_PARAMS*DATA_WIDTH-1:0] PARAM_VALUES = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INDEX_WIDTH-1:0] start_index,
  input  logic                   single,
  input  logic                   abort,
  output logic                   busy,
  output logic                   index_error,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [INDEX_WIDTH-1:0] out_dest,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic [INDEX_WIDTH-1:0] words_sent
);
  localparam int AW = N_PARAMS > 1 ? $clog2(N_PARAMS) : 1;
  localparam logic [INDEX_WIDTH-1:0] N_IDX = INDEX_WIDTH'(N_PARAMS);
  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(N_PARAMS - 1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_n;
  logic [INDEX_WIDTH-1:0] idx, idx_n, ws_n;
  logic single_q, single_n, err_n, send;
  logic [DATA_WIDTH-1:0] tbl [2**AW];
  // Power-of-two padded table so the index slice never reads outside it
  for (genvar i = 0; i < 2**AW; i++) begin : g_tbl
    if (i < N_PARAMS) begin : g_val
      assign tbl[i] = PARAM_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pad
      assign tbl[i] = '0;
    end
  end
  assign send = state == SEND;
  assign busy = send;
  assign out_valid = send;
  assign out_data = send ? tbl[idx[AW-1:0]] : '0;
  assign out_dest = send ? idx : '0;
  assign out_last = send && (single_q || idx == LAST_IDX);
  always_comb begin
    state_n = state;
    idx_n = idx;
    single_n = single_q;
    ws_n = words_sent;
    err_n = 1'b0;
    if (!send) begin
      if (start) begin
        err_n = start_index >= N_IDX;
        if (start_index < N_IDX) begin
          idx_n = start_index;
          single_n = single;
          ws_n = '0;
          state_n = SEND;
        end
      end
    end else begin
      if (out_ready) begin
        ws_n = words_sent + 1'b1;
        idx_n = out_last ? idx : idx + 1'b1;
        state_n = out_last ? IDLE : SEND;
      end
      if (abort) state_n = IDLE;
    end
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      idx <= '0;
      single_q <= 1'b0;
      words_sent <= '0;
      index_error <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      single_q <= single_n;
      words_sent <= ws_n;
      index_error <= err_n;
    end
  end
endmodule

// File: tb/tb_param_table_streamer.sv
// tb_param_table_streamer: vector table plus corner-case sequences, with a beat
// scoreboard fed at stimulus time and drained by a negedge handshake monitor.
module tb_param_table_streamer;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, single = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [2:0] start_index = '0;
  logic busy, index_error, out_valid, out_last;
  logic [31:0] out_data;
  logic [2:0] out_dest, words_sent;

  param_table_streamer #(
    .N_PARAMS(4), .DATA_WIDTH(32), .INDEX_WIDTH(3),
    .PARAM_VALUES({32'd74, 32'd63, 32'd8, 32'd32})
  ) dut (
    .clock(clock), .reset(reset), .start(start), .start_index(start_index),
    .single(single), .abort(abort), .busy(busy), .index_error(index_error),
    .out_data(out_data), .out_dest(out_dest), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .words_sent(words_sent)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [2:0] dest;
    logic last;
  } beat_t;
  typedef struct {
    logic [2:0] sidx;
    logic single;
    logic err;
    int words;
  } vec_t;

  logic [31:0] tbl_ref [4] = '{32'd32, 32'd8, 32'd63, 32'd74};
  beat_t exp_q[$];
  beat_t prev, got;
  logic prev_stall = 1'b0, prev_abort = 1'b0;
  int checks = 0, failures = 0, err_cnt = 0, last_ws = 0;
  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) prev_stall = 1'b0;
    else begin
      if (prev_stall && !prev_abort) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev.data);
        chk("stall_dest", out_dest, prev.dest);
        chk("stall_last", out_last, prev.last);
      end
      if (index_error) err_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual_dest=%0d actual_data=%0d required=none", out_dest, out_data);
        end else begin
          got = exp_q.pop_front();
          chk("beat_data", out_data, got.data);
          chk("beat_dest", out_dest, got.dest);
          chk("beat_last", out_last, got.last);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev = '{out_data, out_dest, out_last};
      prev_abort = abort;
    end
  end

  task automatic push_beats(input int sidx, input logic sgl);
    int last_i;
    last_i = sgl ? sidx : 3;
    for (int i = sidx; i <= last_i; i++) exp_q.push_back('{tbl_ref[i], 3'(i), i == last_i});
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && busy; i++) tick();
    chk("idle_timeout", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int e0;
    e0 = err_cnt;
    tick();
    start = 1'b1;
    start_index = v.sidx;
    single = v.single;
    out_ready = 1'b1;
    if (!v.err) push_beats(v.sidx, v.single);
    tick();
    start = 1'b0;
    chk("first_valid", out_valid, !v.err);
    chk("busy_after_start", busy, !v.err);
    wait_idle();
    repeat (3) tick();
    chk("err_pulses", err_cnt - e0, v.err);
    if (!v.err) last_ws = v.words;
    chk("words_sent", words_sent, last_ws);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    vecs[0] = '{3'd0, 1'b0, 1'b0, 4};
    vecs[1] = '{3'd2, 1'b1, 1'b0, 1};
    vecs[2] = '{3'd4, 1'b0, 1'b1, 0};
    vecs[3] = '{3'd3, 1'b0, 1'b0, 1};
    vecs[4] = '{3'd1, 1'b0, 1'b0, 3};
    vecs[5] = '{3'd7, 1'b1, 1'b1, 0};
    vecs[6] = '{3'd0, 1'b1, 1'b0, 1};
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_data", out_data, 0);
    chk("rst_dest", out_dest, 0);
    chk("rst_words", words_sent, 0);
    chk("rst_err", index_error, 0);
    tick();
    reset = 1'b1;
    repeat (2) tick();
    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // stalls: ready pattern 1,0,0,1 repeating
    tick();
    start = 1'b1;
    start_index = 3'd1;
    single = 1'b0;
    out_ready = 1'b1;
    push_beats(1, 1'b0);
    for (int k = 0; k < 40; k++) begin
      tick();
      start = 1'b0;
      out_ready = (k % 4 == 0) || (k % 4 == 3);
      if (!busy) break;
    end
    chk("stall_idle", busy, 0);
    chk("stall_words", words_sent, 3);
    chk("stall_queue", exp_q.size(), 0);

    // abort after the second handshake, with the sink stalled
    tick();
    start = 1'b1;
    start_index = 3'd0;
    out_ready = 1'b1;
    exp_q.push_back('{32'd32, 3'd0, 1'b0});
    exp_q.push_back('{32'd8, 3'd1, 1'b0});
    tick();
    start = 1'b0;
    repeat (2) tick();
    abort = 1'b1;
    out_ready = 1'b0;
    tick();
    abort = 1'b0;
    out_ready = 1'b1;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_words", words_sent, 2);
    chk("abort_queue", exp_q.size(), 0);
    run_vec(vecs[0]);

    // abort coinciding with a handshake still counts that word
    tick();
    start = 1'b1;
    start_index = 3'd1;
    out_ready = 1'b1;
    exp_q.push_back('{32'd8, 3'd1, 1'b0});
    tick();
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_hs_valid", out_valid, 0);
    chk("abort_hs_words", words_sent, 1);
    chk("abort_hs_queue", exp_q.size(), 0);

    // reset mid-transfer while stalled on the last entry
    tick();
    start = 1'b1;
    start_index = 3'd3;
    out_ready = 1'b0;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_last", out_last, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_words", words_sent, 0);
    tick();
    reset = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
